sipo_comma_align: RTL and testbench
===================================

# sipo_comma_align

Serial-to-parallel receive deserializer for the 8b/10b link. It is the receive-side counterpart of the transmit PISO, which sends each 10-bit symbol LSB first (bit `a` first). The block shifts in one serial bit per `bit_en` strobe and hunts for the K28.5 comma to find the symbol boundary. Once locked, it delivers aligned 10-bit symbols with a one-cycle `word_valid` pulse to the downstream 8b/10b decoder.

## Interface
- `LOSS_CNT`, default 3: number of consecutive misaligned commas that drops lock; legal range 1..15.
- `clk` in 1: rising-edge clock.
- `reset` in 1: asynchronous, active-high.
- `bit_en` in 1: serial bit strobe; `serial_in` is sampled on the rising edge where `bit_en`=1.
- `serial_in` in 1: serial data, first bit = symbol bit `a`.
- `resync` in 1: synchronous request to drop lock and re-hunt.
- `word_out` out 10: aligned symbol, with `a` at bit 0 and `j` at bit 9.
- `word_valid` out 1: one-cycle pulse; `word_out` is valid in that cycle.
- `locked` out 1: boundary acquired.
- `comma_det` out 1: one-cycle pulse when an aligned comma is delivered.
- `realign_cnt` out 8: saturating count of lock acquisitions (see Configuration).

## Operation
- Shift register `sr[9:0]`. On `bit_en`: `sr <= {serial_in, sr[9:1]}`. The oldest bit sits in `sr[0]`.
- Comma test is on the post-shift value: `sr[6:0]` == 7'b1111100 (K28.5 RD−) or 7'b0000011 (RD+).
- Bit counter `bcnt[3:0]` runs 0..9 in LOCKED. Miss counter `miss[3:0]` counts misaligned commas.
- **HUNT** (reset state, `locked`=0):
  - On each `bit_en`, test for comma.
  - On a match: output the post-shift `sr` as `word_out`, pulse `word_valid` and `comma_det`, set `bcnt`=0, `miss`=0, and go to LOCKED.
  - No word is output in HUNT before a match.
- **LOCKED** (`locked`=1), on each `bit_en`:
  - If `bcnt`==9: output the post-shift `sr`, pulse `word_valid`, set `bcnt`=0.
    - If the word is a comma: pulse `comma_det` and clear `miss`.
  - Otherwise: `bcnt` += 1.
    - If a comma matches at this non-boundary position: `miss` += 1.
    - When `miss` would reach `LOSS_CNT`: go to HUNT, clear `miss`; this bit produces no word.
- `resync`=1 takes effect at any edge:
  - State → HUNT, `bcnt`=0, `miss`=0.
  - If `bit_en` is also 1: the bit is still shifted into `sr`, but no word and no comma pulse is produced on that edge.
- Non-comma data never causes a transition. Only comma matches affect alignment.

## Timing
- All outputs are registered. `word_out`, `word_valid` and `comma_det` update on the same edge that samples the 10th bit of a symbol. Latency is 0 clocks after the sampling edge (visible in the following cycle).
- `word_valid` and `comma_det` are high for exactly one `clk` cycle per event, even if `bit_en` is held high continuously.
- `word_out` holds its last value between pulses.
- `bit_en` may be asserted every cycle; there is no minimum gap.
- Reset values: `sr`=0, `word_out`=0, `word_valid`=0, `comma_det`=0, `locked`=0, `realign_cnt`=0, `bcnt`=0, `miss`=0, state HUNT.
- `reset` asserted mid-symbol discards the partial symbol immediately, with no output pulse.

## Configuration
- Macro `SIPO_REALIGN_STATS_EN`.
- Defined: `realign_cnt` increments on every HUNT→LOCKED transition and saturates at 8'hFF. It is cleared only by `reset`.
- Undefined: the counter logic is not built and `realign_cnt` is tied to 8'h00. All other behaviour is identical.

## Test plan
- Acquire lock: 3 random bits, then repeated K28.5 RD− (a..j = 0011111010, LSB first). The first comma completes → `locked`=1, `word_out`=10'h17C, `word_valid` and `comma_det` pulse; every 10 bits after → 10'h17C again.
- RD+ comma: send 1100000101 then D21.5 (1010101010) ×4 → first word 10'h283; then four words of 10'h155 with `comma_det`=0 and `locked` held at 1.
- Loss of lock (`LOSS_CNT`=3): while locked, slip the stream by 4 bits with commas every 10 bits → after the 3rd misaligned comma `locked`=0; the next comma relocks at the new boundary. With `SIPO_REALIGN_STATS_EN`, `realign_cnt` goes 1→2.
- Miss cleared: 2 misaligned commas, then 1 aligned comma, then 2 more misaligned → `locked` stays 1.
- `resync` and `bit_en` on the same edge as the 10th bit of a symbol → no `word_valid`, `locked`=0 next cycle; relock on the next comma.
- Async `reset` pulse mid-symbol while locked → all outputs 0 immediately; 50 cycles of `bit_en` held high with `serial_in`=0 → no `word_valid`.

Source files
------------

// File: rtl/sipo_comma_align.sv
// Receive-side 8b/10b deserializer: shifts in LSB-first serial bits and aligns to the K28.5 comma.
// Optional lock-acquisition counter is built when SIPO_REALIGN_STATS_EN is defined.
module sipo_comma_align #(
    parameter int unsigned LOSS_CNT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       serial_in,
    input  logic       resync,
    output logic [9:0] word_out,
    output logic       word_valid,
    output logic       locked,
    output logic       comma_det,
    output logic [7:0] realign_cnt
);

    localparam int unsigned W    = 10;
    localparam int unsigned CW   = 4;
    localparam int unsigned MW   = 5;
    localparam int unsigned RW   = 8;
    localparam logic [6:0] K_NEG = 7'b1111100;
    localparam logic [6:0] K_POS = 7'b0000011;
    localparam logic [CW-1:0] LAST_BIT = CW'(W - 1);

    typedef enum logic {
        ST_HUNT   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t          state, state_nxt;
    // Bit 0 of the window drops out on every shift, so only the upper nine bits are stored.
    logic [W-1:1]    sr, sr_nxt;
    logic [CW-1:0]   bcnt, bcnt_nxt;
    logic [CW-1:0]   miss, miss_nxt;
    logic [W-1:0]    word_nxt;
    logic            word_valid_nxt;
    logic            comma_det_nxt;
    logic [W-1:0]    sr_shift;
    logic            is_comma;
    logic [MW-1:0]   miss_inc;

    assign sr_shift = {serial_in, sr};
    assign is_comma = (sr_shift[6:0] == K_NEG) || (sr_shift[6:0] == K_POS);
    assign miss_inc = MW'(miss) + MW'(1);
    assign locked   = (state == ST_LOCKED);

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= ST_HUNT;
            sr         <= '0;
            bcnt       <= '0;
            miss       <= '0;
            word_out   <= '0;
            word_valid <= 1'b0;
            comma_det  <= 1'b0;
        end else begin
            state      <= state_nxt;
            sr         <= sr_nxt;
            bcnt       <= bcnt_nxt;
            miss       <= miss_nxt;
            word_out   <= word_nxt;
            word_valid <= word_valid_nxt;
            comma_det  <= comma_det_nxt;
        end
    end

    // Next-state: hunt for a comma, then frame every tenth bit and track misaligned commas.
    always_comb begin
        state_nxt      = state;
        sr_nxt         = sr;
        bcnt_nxt       = bcnt;
        miss_nxt       = miss;
        word_nxt       = word_out;
        word_valid_nxt = 1'b0;
        comma_det_nxt  = 1'b0;

        if (bit_en) begin
            sr_nxt = sr_shift[W-1:1];
        end

        if (resync) begin
            state_nxt = ST_HUNT;
            bcnt_nxt  = '0;
            miss_nxt  = '0;
        end else if (bit_en) begin
            if (state == ST_HUNT) begin
                if (is_comma) begin
                    word_nxt       = sr_shift;
                    word_valid_nxt = 1'b1;
                    comma_det_nxt  = 1'b1;
                    bcnt_nxt       = '0;
                    miss_nxt       = '0;
                    state_nxt      = ST_LOCKED;
                end
            end else begin
                if (bcnt == LAST_BIT) begin
                    word_nxt       = sr_shift;
                    word_valid_nxt = 1'b1;
                    bcnt_nxt       = '0;
                    if (is_comma) begin
                        comma_det_nxt = 1'b1;
                        miss_nxt      = '0;
                    end
                end else begin
                    bcnt_nxt = bcnt + CW'(1);
                    if (is_comma) begin
                        if (miss_inc == MW'(LOSS_CNT)) begin
                            state_nxt = ST_HUNT;
                            miss_nxt  = '0;
                            bcnt_nxt  = '0;
                        end else begin
                            miss_nxt = miss_inc[CW-1:0];
                        end
                    end
                end
            end
        end
    end

`ifdef SIPO_REALIGN_STATS_EN
    logic          acquire;
    logic [RW-1:0] realign_q;

    assign acquire     = (state == ST_HUNT) && (state_nxt == ST_LOCKED);
    assign realign_cnt = realign_q;

    // Saturating count of HUNT->LOCKED transitions.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            realign_q <= '0;
        end else if (acquire && (realign_q != {RW{1'b1}})) begin
            realign_q <= realign_q + RW'(1);
        end
    end
`else
    assign realign_cnt = RW'(0);
`endif

endmodule

// File: tb/tb_sipo_comma_align.sv
// Directed self-checking bench for sipo_comma_align: lock, RD+ comma, loss of lock,
// miss clearing, resync on a boundary, and async reset mid-symbol.
module tb_sipo_comma_align;

    localparam logic [9:0] K_NEG = 10'h17C;
    localparam logic [9:0] K_POS = 10'h283;
    localparam logic [9:0] D21_5 = 10'h155;

    logic       clk = 1'b0;
    logic       reset;
    logic       bit_en;
    logic       serial_in;
    logic       resync;
    logic [9:0] word_out;
    logic       word_valid;
    logic       locked;
    logic       comma_det;
    logic [7:0] realign_cnt;

    int         n_cmp = 0;
    int         n_err = 0;
    int         vcnt  = 0;
    int         ccnt  = 0;
    logic [9:0] last_word = 10'h000;

    sipo_comma_align #(.LOSS_CNT(3)) dut (
        .clk        (clk),
        .reset      (reset),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .resync     (resync),
        .word_out   (word_out),
        .word_valid (word_valid),
        .locked     (locked),
        .comma_det  (comma_det),
        .realign_cnt(realign_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_rc(input int n);
`ifdef SIPO_REALIGN_STATS_EN
        return 32'(n);
`else
        return 32'(n - n);
`endif
    endfunction

    task automatic shift_bit(input logic b, input logic rs);
        @(negedge clk);
        bit_en    = 1'b1;
        serial_in = b;
        resync    = rs;
        @(posedge clk);
        #1;
        if (word_valid) begin
            vcnt++;
            last_word = word_out;
        end
        if (comma_det) ccnt++;
    endtask

    task automatic send_sym(input logic [9:0] s);
        for (int i = 0; i < 10; i++) shift_bit(s[i], 1'b0);
    endtask

    task automatic send_zeros(input int n);
        for (int i = 0; i < n; i++) shift_bit(1'b0, 1'b0);
    endtask

    task automatic clr();
        vcnt = 0;
        ccnt = 0;
    endtask

    initial begin
        logic [9:0] sym;
        reset     = 1'b1;
        bit_en    = 1'b0;
        serial_in = 1'b0;
        resync    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_word_out", 32'(word_out), 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_locked", 32'(locked), 32'h0);
        check("rst_comma_det", 32'(comma_det), 32'h0);
        check("rst_realign", 32'(realign_cnt), 32'h0);

        // Acquire lock on K28.5 RD- after three stray bits.
        shift_bit(1'b1, 1'b0);
        shift_bit(1'b0, 1'b0);
        shift_bit(1'b1, 1'b0);
        clr();
        send_sym(K_NEG);
        check("acq_valid_now", 32'(word_valid), 32'h1);
        check("acq_vcnt", 32'(vcnt), 32'd1);
        check("acq_ccnt", 32'(ccnt), 32'd1);
        check("acq_word", 32'(last_word), 32'h17C);
        check("acq_locked", 32'(locked), 32'h1);
        check("acq_realign", 32'(realign_cnt), exp_rc(1));
        @(negedge clk);
        bit_en = 1'b0;
        @(posedge clk);
        #1;
        check("pulse_one_cycle", 32'(word_valid), 32'h0);
        check("word_hold", 32'(word_out), 32'h17C);
        clr();
        send_sym(K_NEG);
        send_sym(K_NEG);
        check("repeat_vcnt", 32'(vcnt), 32'd2);
        check("repeat_ccnt", 32'(ccnt), 32'd2);
        check("repeat_word", 32'(last_word), 32'h17C);

        // RD+ comma followed by D21.5 data.
        clr();
        send_sym(K_POS);
        check("rdp_word", 32'(last_word), 32'h283);
        check("rdp_ccnt", 32'(ccnt), 32'd1);
        clr();
        for (int i = 0; i < 4; i++) send_sym(D21_5);
        check("d215_vcnt", 32'(vcnt), 32'd4);
        check("d215_ccnt", 32'(ccnt), 32'd0);
        check("d215_word", 32'(last_word), 32'h155);
        check("d215_locked", 32'(locked), 32'h1);

        // Slip by four bits: third misaligned comma drops lock, next comma relocks.
        clr();
        send_zeros(4);
        send_sym(K_NEG);
        send_sym(K_NEG);
        check("slip2_locked", 32'(locked), 32'h1);
        send_sym(K_NEG);
        check("slip3_locked", 32'(locked), 32'h0);
        check("slip_vcnt", 32'(vcnt), 32'd3);
        check("slip_ccnt", 32'(ccnt), 32'd0);
        clr();
        send_sym(K_NEG);
        check("relock_locked", 32'(locked), 32'h1);
        check("relock_vcnt", 32'(vcnt), 32'd1);
        check("relock_ccnt", 32'(ccnt), 32'd1);
        check("relock_word", 32'(last_word), 32'h17C);
        check("relock_realign", 32'(realign_cnt), exp_rc(2));

        // Two misses, an aligned comma, two more misses: lock holds.
        clr();
        send_zeros(4);
        send_sym(K_NEG);
        send_sym(K_NEG);
        check("miss2_locked", 32'(locked), 32'h1);
        send_zeros(6);
        send_sym(K_NEG);
        check("missclr_vcnt", 32'(vcnt), 32'd4);
        check("missclr_ccnt", 32'(ccnt), 32'd1);
        check("missclr_word", 32'(last_word), 32'h17C);
        send_zeros(4);
        send_sym(K_NEG);
        send_sym(K_NEG);
        check("missclr_locked", 32'(locked), 32'h1);

        // Resync coincident with the tenth bit of an aligned symbol.
        send_zeros(6);
        send_sym(K_NEG);
        clr();
        sym = K_NEG;
        for (int i = 0; i < 9; i++) shift_bit(sym[i], 1'b0);
        shift_bit(sym[9], 1'b1);
        check("resync_valid", 32'(word_valid), 32'h0);
        check("resync_vcnt", 32'(vcnt), 32'd0);
        check("resync_ccnt", 32'(ccnt), 32'd0);
        check("resync_locked", 32'(locked), 32'h0);
        clr();
        send_sym(K_NEG);
        check("resync_relock", 32'(locked), 32'h1);
        check("resync_rl_vcnt", 32'(vcnt), 32'd1);
        check("resync_rl_word", 32'(last_word), 32'h17C);
        check("resync_realign", 32'(realign_cnt), exp_rc(3));

        // Async reset mid-symbol while locked.
        for (int i = 0; i < 5; i++) shift_bit(sym[i], 1'b0);
        #3;
        reset = 1'b1;
        #1;
        check("arst_locked", 32'(locked), 32'h0);
        check("arst_word_out", 32'(word_out), 32'h0);
        check("arst_word_valid", 32'(word_valid), 32'h0);
        check("arst_comma_det", 32'(comma_det), 32'h0);
        check("arst_realign", 32'(realign_cnt), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        clr();
        send_zeros(50);
        check("zeros_vcnt", 32'(vcnt), 32'd0);
        check("zeros_locked", 32'(locked), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
